vram_fill_ctrl: RTL

- Sequences all writes into the GPU VRAM write port.
- Shares that single port between CPU direct pixel writes from the IO-bus wrapper and a hardware rectangle-fill engine.
- The CPU programs the fill origin, size and colour, then starts the fill. The block walks the rectangle in raster order and emits one pixel write per free cycle.
- Sits between the IO-bus output register decode and the GPU vram_we/addr/data inputs.

---
 rtl/vram_fill_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/vram_fill_ctrl.sv
// vram_fill_ctrl: owns the single GPU VRAM write port. Each cycle the port
// carries either a CPU direct pixel write, which always wins, or one pixel of
// a hardware rectangle fill walked in raster order.
//
// Ports:
//   clk, RST                 clock, asynchronous active-high reset
//   cpu_we_i/addr_i/data_i   CPU direct pixel write (one-cycle strobe)
//   cfg_we_i/sel_i/data_i    config writes: 0 origin, 1 size, 2 colour, 3 control
//   vram_we_o/addr_o/data_o  registered VRAM write port
//   busy_o                   fill in progress
//   done_o                   sticky, last fill completed normally
module vram_fill_ctrl #(
  parameter int unsigned H_RES  = 160,
  parameter int unsigned V_RES  = 120,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_sel_i,
  input  logic [31:0]       cfg_data_i,
  output logic              vram_we_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [DATA_W-1:0] vram_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CW = 16;
  localparam int unsigned EW = 17;
  localparam logic [EW-1:0] H_LIM = EW'(H_RES);
  localparam logic [EW-1:0] V_LIM = EW'(V_RES);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_FINISH} state_t;

  state_t state_q, state_d;

  // Shadow registers, written by the CPU at any time
  logic [CW-1:0]     sh_x_q, sh_y_q, sh_w_q, sh_h_q;
  logic [DATA_W-1:0] sh_col_q;

  // Working registers for the active fill
  logic [CW-1:0]     wk_x_q, wk_y_q, wk_w_q, wk_h_q;
  logic [CW-1:0]     wk_x_d, wk_y_d, wk_w_d, wk_h_d;
  logic [DATA_W-1:0] wk_col_q, wk_col_d;
  logic [EW-1:0]     x_end_q, x_end_d, y_end_q, y_end_d;
  logic [CW-1:0]     col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  logic              vram_we_d;
  logic [ADDR_W-1:0] vram_addr_d;
  logic [DATA_W-1:0] vram_data_d;
  logic              busy_d, done_d;

  logic              start_c, abort_c;
  logic [EW-1:0]     x_sum_c, y_sum_c, x_clip_c, y_clip_c;
  logic              empty_c;
  logic [ADDR_W-1:0] row_base0_c, fill_addr_c;
  logic              last_col_c, last_row_c;

  // Control register strobes; never stored
  assign start_c = cfg_we_i && (cfg_sel_i == 2'd3) && cfg_data_i[0];
  assign abort_c = cfg_we_i && (cfg_sel_i == 2'd3) && cfg_data_i[1];

  // Clip arithmetic at 17 bits so x+w / y+h cannot wrap
  assign x_sum_c  = EW'(wk_x_q) + EW'(wk_w_q);
  assign y_sum_c  = EW'(wk_y_q) + EW'(wk_h_q);
  assign x_clip_c = (x_sum_c > H_LIM) ? H_LIM : x_sum_c;
  assign y_clip_c = (y_sum_c > V_LIM) ? V_LIM : y_sum_c;
  assign empty_c  = (wk_w_q == '0) || (wk_h_q == '0) ||
                    (EW'(wk_x_q) >= H_LIM) || (EW'(wk_y_q) >= V_LIM);

  // Constant multiply; y is below V_RES here so this reduces to a small shift-add
  assign row_base0_c = ADDR_W'(32'(wk_y_q) * 32'(H_RES) + 32'(wk_x_q));

  assign fill_addr_c = row_base_q + ADDR_W'(col_q - wk_x_q);
  assign last_col_c  = (EW'(col_q) + EW'(1)) == x_end_q;
  assign last_row_c  = (EW'(row_q) + EW'(1)) == y_end_q;

  // Shadow register writes
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      sh_w_q   <= '0;
      sh_h_q   <= '0;
      sh_col_q <= '0;
    end else if (cfg_we_i) begin
      case (cfg_sel_i)
        2'd0: begin
          sh_x_q <= cfg_data_i[15:0];
          sh_y_q <= cfg_data_i[31:16];
        end
        2'd1: begin
          sh_w_q <= cfg_data_i[15:0];
          sh_h_q <= cfg_data_i[31:16];
        end
        2'd2:    sh_col_q <= cfg_data_i[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  // Next-state, arbitration and fill walk
  always_comb begin
    state_d     = state_q;
    wk_x_d      = wk_x_q;
    wk_y_d      = wk_y_q;
    wk_w_d      = wk_w_q;
    wk_h_d      = wk_h_q;
    wk_col_d    = wk_col_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    vram_we_d   = 1'b0;
    vram_addr_d = vram_addr_o;
    vram_data_d = vram_data_o;
    busy_d      = busy_o;
    done_d      = done_o;

    // CPU write always takes the port
    if (cpu_we_i) begin
      vram_we_d   = 1'b1;
      vram_addr_d = cpu_addr_i;
      vram_data_d = cpu_data_i;
    end

    case (state_q)
      S_IDLE: begin
        if (start_c && !abort_c) begin
          wk_x_d   = sh_x_q;
          wk_y_d   = sh_y_q;
          wk_w_d   = sh_w_q;
          wk_h_d   = sh_h_q;
          wk_col_d = sh_col_q;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort_c) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (empty_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          x_end_d    = x_clip_c;
          y_end_d    = y_clip_c;
          row_base_d = row_base0_c;
          col_d      = wk_x_q;
          row_d      = wk_y_q;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (abort_c) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!cpu_we_i) begin
          vram_we_d   = 1'b1;
          vram_addr_d = fill_addr_c;
          vram_data_d = wk_col_q;
          if (last_col_c) begin
            if (last_row_c) begin
              state_d = S_FINISH;
            end else begin
              col_d      = wk_x_q;
              row_d      = row_q + CW'(1);
              row_base_d = row_base_q + ADDR_W'(H_RES);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_FINISH: begin
        // Last pixel is on the port; report completion one edge later
        busy_d  = 1'b0;
        done_d  = !abort_c;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      wk_x_q      <= '0;
      wk_y_q      <= '0;
      wk_w_q      <= '0;
      wk_h_q      <= '0;
      wk_col_q    <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      vram_we_o   <= 1'b0;
      vram_addr_o <= '0;
      vram_data_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wk_x_q      <= wk_x_d;
      wk_y_q      <= wk_y_d;
      wk_w_q      <= wk_w_d;
      wk_h_q      <= wk_h_d;
      wk_col_q    <= wk_col_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      vram_we_o   <= vram_we_d;
      vram_addr_o <= vram_addr_d;
      vram_data_o <= vram_data_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
    end
  end

endmodule
